// File: rtl/wb_master_bridge.sv
// wb_master_bridge: pipelined Wishbone B4 master fed by a valid/ready request stream.
// Issues one transfer per cycle and returns responses in request order. A credit counter
// caps the number of requests in flight, so the response FIFO always has room for an ack.
//
// Ports
//   clk_i, rst_i            clock; asynchronous active-low reset
//   req_*                   request stream in (valid/ready, addr, wdata, sel, we)
//   resp_*                  response stream out (valid/ready, data, we)
//   err_o                   sticky: an ack arrived with nothing outstanding
//   addr_o..stb_o, cti_o    Wishbone master outputs
//   data_i, ack_i, stall_i  Wishbone slave returns
module wb_master_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_sel_i,
  input  logic        req_we_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic        resp_we_o,
  output logic        err_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  input  logic [31:0] data_i,
  output logic [3:0]  sel_o,
  output logic        we_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [2:0]  cti_o,
  input  logic        ack_i,
  input  logic        stall_i
);

  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTSTANDING - 1);

  // Issue register
  logic              r_stb;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_sel;
  logic              r_we;

  // Counters
  logic [CntW-1:0]   r_credits;
  logic [CntW-1:0]   r_bus_cnt;
  logic [CntW-1:0]   r_resp_cnt;
  logic              r_err;

  // Tag FIFO: write flag of each transfer the slave has taken but not acked
  logic              r_tag_mem [MAX_OUTSTANDING];
  logic [PtrW-1:0]   r_tag_wr;
  logic [PtrW-1:0]   r_tag_rd;

  // Response FIFO: {we, data}
  logic [32:0]       r_resp_mem [MAX_OUTSTANDING];
  logic [PtrW-1:0]   r_resp_wr;
  logic [PtrW-1:0]   r_resp_rd;

  logic              w_req_acc;
  logic              w_bus_acc;
  logic              w_ack_ok;
  logic              w_ack_bad;
  logic              w_pop;
  logic              w_ack_tag;
  logic [32:0]       w_resp_head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  assign req_ready_o = (!r_stb || !stall_i) && (r_credits < CntMax);
  assign w_req_acc   = req_valid_i && req_ready_o;
  assign w_bus_acc   = r_stb && !stall_i;
  assign w_ack_ok    = ack_i && (r_bus_cnt != '0);
  assign w_ack_bad   = ack_i && (r_bus_cnt == '0);
  assign w_pop       = resp_valid_o && resp_ready_i;
  assign w_ack_tag   = r_tag_mem[r_tag_rd];
  assign w_resp_head = r_resp_mem[r_resp_rd];

  assign stb_o  = r_stb;
  assign addr_o = r_addr;
  assign data_o = r_wdata;
  assign sel_o  = r_sel;
  assign we_o   = r_we;
  assign cti_o  = 3'b111;
  // Both terms are registered, so cyc_o stays clean across back-to-back transfers.
  assign cyc_o  = r_stb || (r_bus_cnt != '0);
  assign err_o  = r_err;

  // Storage beyond the head is never observed, so output zeros whenever the FIFO is empty.
  assign resp_valid_o = (r_resp_cnt != '0);
  assign resp_we_o    = resp_valid_o && w_resp_head[32];
  assign resp_data_o  = resp_valid_o ? w_resp_head[31:0] : 32'h0;

  // Issue register: a new accept overrides the clear, keeping stb high back-to-back.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stb   <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_sel   <= 4'h0;
      r_we    <= 1'b0;
    end else if (w_req_acc) begin
      r_stb   <= 1'b1;
      r_addr  <= req_addr_i;
      r_wdata <= req_wdata_i;
      r_sel   <= req_sel_i;
      r_we    <= req_we_i;
    end else if (w_bus_acc) begin
      r_stb   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_credits  <= '0;
      r_bus_cnt  <= '0;
      r_resp_cnt <= '0;
      r_err      <= 1'b0;
      r_tag_wr   <= '0;
      r_tag_rd   <= '0;
      r_resp_wr  <= '0;
      r_resp_rd  <= '0;
    end else begin
      unique case ({w_req_acc, w_pop})
        2'b10:   r_credits <= r_credits + 1'b1;
        2'b01:   r_credits <= r_credits - 1'b1;
        default: r_credits <= r_credits;
      endcase
      unique case ({w_bus_acc, w_ack_ok})
        2'b10:   r_bus_cnt <= r_bus_cnt + 1'b1;
        2'b01:   r_bus_cnt <= r_bus_cnt - 1'b1;
        default: r_bus_cnt <= r_bus_cnt;
      endcase
      unique case ({w_ack_ok, w_pop})
        2'b10:   r_resp_cnt <= r_resp_cnt + 1'b1;
        2'b01:   r_resp_cnt <= r_resp_cnt - 1'b1;
        default: r_resp_cnt <= r_resp_cnt;
      endcase
      if (w_bus_acc) r_tag_wr  <= ptr_inc(r_tag_wr);
      if (w_ack_ok)  r_tag_rd  <= ptr_inc(r_tag_rd);
      if (w_ack_ok)  r_resp_wr <= ptr_inc(r_resp_wr);
      if (w_pop)     r_resp_rd <= ptr_inc(r_resp_rd);
      if (w_ack_bad) r_err     <= 1'b1;
    end
  end

  // FIFO storage needs no reset: pointers and counts define what is valid.
  always_ff @(posedge clk_i) begin
    if (w_bus_acc) r_tag_mem[r_tag_wr] <= r_we;
    if (w_ack_ok)  r_resp_mem[r_resp_wr] <= {w_ack_tag, w_ack_tag ? 32'h0 : data_i};
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
module tb_wb_master_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_sel_i;
  logic        req_we_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_data_o;
  logic        resp_we_o;
  logic        err_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [31:0] data_i;
  logic [3:0]  sel_o;
  logic        we_o;
  logic        cyc_o;
  logic        stb_o;
  logic [2:0]  cti_o;
  logic        ack_i;
  logic        stall_i;

  logic        slave_ack;
  logic        force_ack;
  logic [32:0] sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          stb_cnt = 0;
  int          stb_run = 0;
  int          max_run = 0;

  always #5 clk_i = ~clk_i;

  wb_master_bridge #(.MAX_OUTSTANDING(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_sel_i    (req_sel_i),
    .req_we_i     (req_we_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .resp_we_o    (resp_we_o),
    .err_o        (err_o),
    .addr_o       (addr_o),
    .data_o       (data_o),
    .data_i       (data_i),
    .sel_o        (sel_o),
    .we_o         (we_o),
    .cyc_o        (cyc_o),
    .stb_o        (stb_o),
    .cti_o        (cti_o),
    .ack_i        (ack_i),
    .stall_i      (stall_i)
  );

  // Zero-wait pipelined slave: ack one cycle after accept, read data = word index.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      slave_ack <= 1'b0;
      data_i    <= 32'h0;
    end else begin
      slave_ack <= cyc_o && stb_o && !stall_i;
      data_i    <= addr_o >> 2;
    end
  end
  assign ack_i = slave_ack | force_ack;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe statistics and response scoreboard, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (stb_o) begin
      stb_cnt++;
      stb_run++;
      if (stb_run > max_run) max_run = stb_run;
    end else begin
      stb_run = 0;
    end
    if (rst_i && resp_valid_o && resp_ready_i) begin
      if (sb.size() == 0) begin
        chk("resp_unexpected", {63'h0, resp_valid_o}, 96'h0);
      end else begin
        chk("resp", {63'h0, resp_we_o, resp_data_o}, {63'h0, sb.pop_front()});
      end
    end
  end

  // Offer n back-to-back requests for at most max_cyc cycles; returns the accepted count.
  task automatic stream(input logic [31:0] base, input logic [31:0] wbase, input logic [3:0] sel,
                        input logic we, input int n, input int max_cyc, output int acc);
    acc = 0;
    req_valid_i = 1'b1;
    req_addr_i  = base;
    req_wdata_i = wbase;
    req_sel_i   = sel;
    req_we_i    = we;
    for (int c = 0; c < max_cyc && acc < n; c++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        sb.push_back(we ? {1'b1, 32'h0} : {1'b0, req_addr_i >> 2});
        acc++;
      end
      @(posedge clk_i);
      #1;
      req_addr_i  = base + 32'(4 * acc);
      req_wdata_i = wbase ^ 32'(4 * acc);
    end
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 100 && sb.size() != 0; c++) begin
      @(posedge clk_i);
      #1;
    end
    chk("drain", 96'(sb.size()), 96'd0);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int base;
    rst_i = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i = 32'h0;
    req_wdata_i = 32'h0;
    req_sel_i = 4'h0;
    req_we_i = 1'b0;
    resp_ready_i = 1'b1;
    stall_i = 1'b0;
    force_ack = 1'b0;

    // Reset state
    step(3);
    chk("rst_ctl", {91'h0, stb_o, cyc_o, we_o, resp_valid_o, err_o}, 96'h0);
    chk("rst_bus", {32'h0, addr_o, data_o}, 96'h0);
    chk("rst_misc", {56'h0, sel_o, resp_data_o, resp_we_o, cti_o}, {56'h0, 4'h0, 32'h0, 1'b0, 3'b111});
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_ready", {95'h0, req_ready_o}, 96'h1);
    step(1);

    // Single write
    base = stb_cnt;
    stream(32'h100, 32'hDEAD_BEEF, 4'hF, 1'b1, 1, 10, acc);
    chk("wr_acc", 96'(acc), 96'd1);
    @(negedge clk_i);
    chk("wr_bus", {32'h0, addr_o, data_o}, {32'h0, 32'h100, 32'hDEAD_BEEF});
    chk("wr_ctl", {90'h0, sel_o, we_o, stb_o}, {90'h0, 4'hF, 1'b1, 1'b1});
    step(1);
    @(negedge clk_i);
    chk("wr_stb_drop", {94'h0, stb_o, cyc_o}, {94'h0, 1'b0, 1'b1});
    step(1);
    @(negedge clk_i);
    chk("wr_cyc_drop", {94'h0, cyc_o, resp_valid_o}, {94'h0, 1'b0, 1'b1});
    drain();
    chk("wr_stb_cnt", 96'(stb_cnt - base), 96'd1);

    // Streamed reads
    step(1);
    base = stb_cnt;
    max_run = 0;
    stream(32'h0, 32'h0, 4'hF, 1'b0, 4, 10, acc);
    chk("rd_acc", 96'(acc), 96'd4);
    drain();
    chk("rd_stb_cnt", 96'(stb_cnt - base), 96'd4);
    chk("rd_stb_run", 96'(max_run), 96'd4);

    // Stall hold on the 2nd of 3 requests
    step(1);
    stream(32'h300, 32'h5555_0000, 4'h3, 1'b0, 2, 10, acc);
    chk("st_acc", 96'(acc), 96'd2);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("st_ready", {95'h0, req_ready_o}, 96'h0);
      chk("st_bus", {32'h0, addr_o, data_o}, {32'h0, 32'h304, 32'h5555_0004});
      chk("st_ctl", {90'h0, sel_o, we_o, stb_o}, {90'h0, 4'h3, 1'b0, 1'b1});
      step(1);
    end
    stall_i = 1'b0;
    stream(32'h308, 32'h5555_0008, 4'h3, 1'b0, 1, 10, acc);
    chk("st_acc3", 96'(acc), 96'd1);
    drain();

    // Credit limit
    step(1);
    resp_ready_i = 1'b0;
    stream(32'h200, 32'h0, 4'hF, 1'b0, 6, 12, acc);
    chk("cr_acc4", 96'(acc), 96'd4);
    req_valid_i = 1'b1;
    @(negedge clk_i);
    chk("cr_ready", {95'h0, req_ready_o}, 96'h0);
    step(1);
    resp_ready_i = 1'b1;
    stream(32'h210, 32'h0, 4'hF, 1'b0, 2, 20, acc);
    chk("cr_acc2", 96'(acc), 96'd2);
    drain();

    // Spurious ack while idle
    step(2);
    force_ack = 1'b1;
    step(1);
    force_ack = 1'b0;
    @(negedge clk_i);
    chk("sp_err", {93'h0, err_o, resp_valid_o, cyc_o}, {93'h0, 1'b1, 1'b0, 1'b0});
    step(3);
    @(negedge clk_i);
    chk("sp_sticky", {94'h0, err_o, req_ready_o}, {94'h0, 1'b1, 1'b1});
    step(1);
    stream(32'h40, 32'h0, 4'hF, 1'b0, 1, 10, acc);
    drain();

    // Reset mid-operation: 3 responses held, credits in use
    step(1);
    resp_ready_i = 1'b0;
    stream(32'h80, 32'h0, 4'hF, 1'b0, 3, 10, acc);
    step(4);
    @(negedge clk_i);
    chk("mr_pre", {94'h0, resp_valid_o, err_o}, {94'h0, 1'b1, 1'b1});
    step(1);
    sb.delete();
    rst_i = 1'b0;
    #1;
    chk("mr_ctl", {91'h0, stb_o, cyc_o, we_o, resp_valid_o, err_o}, 96'h0);
    chk("mr_misc", {56'h0, sel_o, resp_data_o, resp_we_o, cti_o}, {56'h0, 4'h0, 32'h0, 1'b0, 3'b111});
    chk("mr_bus", {32'h0, addr_o, data_o}, 96'h0);
    step(1);
    rst_i = 1'b1;
    resp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("mr_ready", {95'h0, req_ready_o}, 96'h1);
    step(1);
    stream(32'h1F0, 32'h0, 4'hF, 1'b0, 1, 10, acc);
    drain();
    step(3);
    chk("mr_quiet", {94'h0, resp_valid_o, cyc_o}, 96'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
